instruction_fetch_queue: RTL and testbench
==========================================

# instruction_fetch_queue

Parametrised fetch front-end for the MIPS pipeline. It generates the fetch PC, issues reads to a synchronous instruction memory port, and buffers returned instructions with their PC+4 in a flushable queue. Decode consumes the queue through a valid/ready handshake. Redirects (branch, jump-immediate, jump-register) flush wrong-path entries and in-flight reads, and restart fetch at the target, so memory latency and decode stalls are decoupled from the PC.

## Interface
- NB_REG, 32, PC/register width
- NB_INSTR, 32, instruction width
- N_ADDR, 2048, instruction memory depth in words
- NB_INM_I, 16, branch immediate width
- NB_INM_J, 26, jump immediate width
- QUEUE_DEPTH, 4, queue entries (power of 2, >=2)
- RESET_PC, 0, PC loaded at reset
- i_clock  in  1  single clock, all state on rising edge
- i_reset_n  in  1  asynchronous, active-low reset
- i_enable  in  1  global step enable (debug unit)
- o_imem_addr  out  clog2(N_ADDR)  word address = pc[clog2(N_ADDR)+1:2]
- o_imem_en  out  1  read request this cycle
- i_imem_data  in  NB_INSTR  read data, valid the cycle after o_imem_en
- o_valid  out  1  queue head valid
- i_ready  in  1  decode accepts head
- o_ir  out  NB_INSTR  head instruction
- o_pc  out  NB_REG  head instruction address + 4
- i_branch, i_jump_rs, i_jump_inm  in  1 each  redirect requests
- i_redirect_pc  in  NB_REG  o_pc of the redirecting instruction
- i_inm_i  in  NB_INM_I  branch offset (words, signed)
- i_inm_j  in  NB_INM_J  jump index
- i_rs  in  NB_REG  register jump target
- o_misaligned  out  1  one-cycle pulse: i_rs[1:0]≠0 on jump_rs
- o_debug_pc  out  NB_REG  current fetch PC

## Operation
- redirect = i_branch|i_jump_rs|i_jump_inm. Priority branch > jump_rs > jump_inm.
- Targets:
  - branch: i_redirect_pc + (sext(i_inm_i)<<2).
  - jump_inm: {i_redirect_pc[31:28], i_inm_j, 2'b00}.
  - jump_rs: {i_rs[31:2], 2'b00}.
  - All arithmetic is mod 2^NB_REG.
- pop = o_valid & i_ready & i_enable.
- issue = i_enable & ~redirect & (count + pending − pop < QUEUE_DEPTH). On issue: pc <= pc+4 and pending <= 1.
- Return: when pending, i_imem_data and its pc+4 are pushed on that edge unless killed. Returns are captured even when i_enable=0. Push and pop in the same cycle are legal.
- On redirect:
  - Queue is emptied on that edge.
  - A pending return arriving next cycle is discarded (kill bit).
  - pc <= target.
  - o_valid is forced 0 during the redirect cycle.
- The memory address wraps modulo N_ADDR; the PC itself is not truncated.

## Timing
- Reset values:
  - pc = RESET_PC; queue empty; pending = 0; kill = 0.
  - o_valid = 0, o_imem_en = 0, o_misaligned = 0.
  - o_ir = 0, o_pc = 0, o_debug_pc = RESET_PC.
- Fetch latency: issue in cycle c → data in c+1 → o_valid in c+2.
- Redirect asserted in cycle r → target fetch issued r+1 → target at head in r+3.
- Throughput: 1 instr/cycle sustained with i_ready=1 and QUEUE_DEPTH≥2.
- Full queue: issue is suppressed, PC is held, and no entry is ever dropped.
- Empty queue: o_valid=0; o_ir/o_pc hold their last values.
- i_enable=0: no issue and no pop; an in-flight return is still enqueued.
- Reset assertion mid-operation: all state clears immediately; in-flight data is ignored after release.

## Structure
- Shared package mips_fetch_pkg holds:
  - NOP encoding.
  - The redirect-type encoding {NONE, BRANCH, JUMP_RS, JUMP_INM}.
  - The clogb2 function.
- Sub-module fetch_queue: a synchronous FIFO of QUEUE_DEPTH × (NB_INSTR+NB_REG) with push, pop and synchronous flush. It provides count, full and empty, and uses pointer wrap via a power-of-2 depth.
- The top level holds the PC register, the pending/kill bits, target muxing and issue logic.

## Test plan
- Sequential fetch: reset with RESET_PC=0, i_ready=1, memory holds word k at address k → o_ir = 0,1,2… one per cycle from cycle 2; o_pc = 4,8,12…
- Backpressure: i_ready=0 for 10 cycles with QUEUE_DEPTH=4 → o_imem_en stops after 4 entries are resident, o_debug_pc=16. Release → words 0..7 delivered in order with none lost.
- Branch: i_branch with i_redirect_pc=0x20 and i_inm_i=−4 → target 0x10, o_valid=0 in cycle r, head word 4 at r+3, and the killed return never appears.
- Jumps: jump_inm with i_redirect_pc=0x3000_0008, i_inm_j=0x40 → fetch at 0x3000_0100. jump_rs with i_rs=0x2A → fetch 0x28 and o_misaligned pulses once.
- Simultaneous events: branch and jump_rs in the same cycle → branch target wins. Push+pop with a full queue → count unchanged.
- Reset/enable: assert i_reset_n=0 mid-stream with pending set → outputs at reset values immediately, and the first post-reset head is the word at RESET_PC. i_enable=0 → the in-flight word is enqueued and no further issue occurs.

Source files
------------

// File: rtl/mips_fetch_pkg.sv
// Shared definitions for the MIPS fetch front-end: NOP encoding, redirect
// selection and a constant-log helper for sizing address and pointer fields.
package mips_fetch_pkg;

   localparam logic [31:0] NOP = 32'h0000_0000;

   typedef enum logic [1:0] {
      REDIR_NONE,
      REDIR_BRANCH,
      REDIR_JUMP_RS,
      REDIR_JUMP_INM
   } redirect_e;

   function automatic int clogb2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r = r + 1;
      return r;
   endfunction

endpackage

// File: rtl/fetch_queue.sv
// Power-of-2 FIFO holding fetched {instruction, pc+4} entries; a synchronous
// flush empties it and takes priority over a push on the same edge.
module fetch_queue
   import mips_fetch_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int WIDTH = 64
) (
   input  logic                     i_clock,
   input  logic                     i_reset_n,
   input  logic                     i_push,
   input  logic                     i_pop,
   input  logic                     i_flush,
   input  logic [WIDTH-1:0]         i_data,
   output logic [WIDTH-1:0]         o_data,
   output logic [clogb2(DEPTH):0]   o_count,
   output logic                     o_full,
   output logic                     o_empty
);

   localparam int NB_PTR = clogb2(DEPTH);

   logic [WIDTH-1:0]  storage [DEPTH];
   logic [NB_PTR-1:0] wr_ptr;
   logic [NB_PTR-1:0] rd_ptr;
   logic [NB_PTR:0]   count;
   logic              do_push;
   logic              do_pop;

   assign o_empty = (count == '0);
   assign o_full  = (count == (NB_PTR+1)'(DEPTH));
   assign o_count = count;
   assign o_data  = storage[rd_ptr];

   assign do_pop  = i_pop & ~o_empty;
   assign do_push = i_push & (~o_full | do_pop);

   always_ff @(posedge i_clock) begin
      if (do_push && !i_flush) storage[wr_ptr] <= i_data;
   end

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (i_flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + NB_PTR'(1);
         if (do_pop)  rd_ptr <= rd_ptr + NB_PTR'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + (NB_PTR+1)'(1);
            2'b01:   count <= count - (NB_PTR+1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/instruction_fetch_queue.sv
// Fetch front-end: PC generation, instruction memory request issue, redirect
// target selection and a flushable queue decoupling decode from memory latency.
module instruction_fetch_queue
   import mips_fetch_pkg::*;
#(
   parameter int                NB_REG      = 32,
   parameter int                NB_INSTR    = 32,
   parameter int                N_ADDR      = 2048,
   parameter int                NB_INM_I    = 16,
   parameter int                NB_INM_J    = 26,
   parameter int                QUEUE_DEPTH = 4,
   parameter logic [NB_REG-1:0] RESET_PC    = '0
) (
   input  logic                        i_clock,
   input  logic                        i_reset_n,
   input  logic                        i_enable,
   output logic [clogb2(N_ADDR)-1:0]   o_imem_addr,
   output logic                        o_imem_en,
   input  logic [NB_INSTR-1:0]         i_imem_data,
   output logic                        o_valid,
   input  logic                        i_ready,
   output logic [NB_INSTR-1:0]         o_ir,
   output logic [NB_REG-1:0]           o_pc,
   input  logic                        i_branch,
   input  logic                        i_jump_rs,
   input  logic                        i_jump_inm,
   input  logic [NB_REG-1:0]           i_redirect_pc,
   input  logic [NB_INM_I-1:0]         i_inm_i,
   input  logic [NB_INM_J-1:0]         i_inm_j,
   input  logic [NB_REG-1:0]           i_rs,
   output logic                        o_misaligned,
   output logic [NB_REG-1:0]           o_debug_pc
);

   localparam int NB_ADDR  = clogb2(N_ADDR);
   localparam int NB_CNT   = clogb2(QUEUE_DEPTH) + 1;
   localparam int NB_ENTRY = NB_INSTR + NB_REG;

   redirect_e           redir_sel;
   logic [NB_REG-1:0]   target;
   logic [NB_REG-1:0]   pc;
   logic [NB_REG-1:0]   pending_pc;
   logic                pending;
   logic                kill;
   logic                misaligned;
   logic                redirect;
   logic                pop;
   logic                push;
   logic                issue;
   logic                q_empty;
   logic                q_full;
   logic [NB_CNT-1:0]   q_count;
   logic [NB_CNT:0]     occupancy;
   logic [NB_ENTRY-1:0] head;
   logic [NB_INSTR-1:0] last_ir;
   logic [NB_REG-1:0]   last_pc;

   always_comb begin
      redir_sel = REDIR_NONE;
      target    = pc;
      if (i_branch) begin
         redir_sel = REDIR_BRANCH;
         target    = i_redirect_pc
                   + {{(NB_REG-NB_INM_I-2){i_inm_i[NB_INM_I-1]}}, i_inm_i, 2'b00};
      end else if (i_jump_rs) begin
         redir_sel = REDIR_JUMP_RS;
         target    = {i_rs[NB_REG-1:2], 2'b00};
      end else if (i_jump_inm) begin
         redir_sel = REDIR_JUMP_INM;
         target    = {i_redirect_pc[NB_REG-1:NB_INM_J+2], i_inm_j, 2'b00};
      end
   end

   assign redirect = (redir_sel != REDIR_NONE);
   assign o_valid  = ~q_empty & ~redirect;
   assign pop      = o_valid & i_ready & i_enable;
   assign push     = pending & ~kill;

   // Entries resident plus the one in flight must leave room after this cycle's pop.
   assign occupancy = {1'b0, q_count} + (NB_CNT+1)'(pending) - (NB_CNT+1)'(pop);
   assign issue     = i_reset_n & i_enable & ~redirect
                    & (occupancy < (NB_CNT+1)'(QUEUE_DEPTH));

   assign o_imem_en    = issue;
   assign o_imem_addr  = pc[NB_ADDR+1:2];
   assign o_debug_pc   = pc;
   assign o_misaligned = misaligned;
   assign o_ir         = q_empty ? last_ir : head[NB_ENTRY-1:NB_REG];
   assign o_pc         = q_empty ? last_pc : head[NB_REG-1:0];

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         pc         <= RESET_PC;
         pending    <= 1'b0;
         pending_pc <= '0;
         kill       <= 1'b0;
         misaligned <= 1'b0;
         last_ir    <= NB_INSTR'(NOP);
         last_pc    <= '0;
      end else begin
         if (redirect)   pc <= target;
         else if (issue) pc <= pc + NB_REG'(4);
         pending <= issue;
         if (issue) pending_pc <= pc + NB_REG'(4);
         // A return landing after the flush edge belongs to the wrong path.
         kill       <= redirect;
         misaligned <= (redir_sel == REDIR_JUMP_RS) & (|i_rs[1:0]);
         if (!q_empty) begin
            last_ir <= head[NB_ENTRY-1:NB_REG];
            last_pc <= head[NB_REG-1:0];
         end
      end
   end

   fetch_queue #(
      .DEPTH (QUEUE_DEPTH),
      .WIDTH (NB_ENTRY)
   ) u_fetch_queue (
      .i_clock   (i_clock),
      .i_reset_n (i_reset_n),
      .i_push    (push),
      .i_pop     (pop),
      .i_flush   (redirect),
      .i_data    ({i_imem_data, pending_pc}),
      .o_data    (head),
      .o_count   (q_count),
      .o_full    (q_full),
      .o_empty   (q_empty)
   );

endmodule

// File: tb/tb_instruction_fetch_queue.sv
// Bench for instruction_fetch_queue: directed scenarios plus a randomized run
// against a program-order reference model of the delivered instruction stream.
module tb_instruction_fetch_queue;

   logic        i_clock;
   logic        i_reset_n;
   logic        i_enable;
   logic [10:0] o_imem_addr;
   logic        o_imem_en;
   logic [31:0] i_imem_data;
   logic        o_valid;
   logic        i_ready;
   logic [31:0] o_ir;
   logic [31:0] o_pc;
   logic        i_branch;
   logic        i_jump_rs;
   logic        i_jump_inm;
   logic [31:0] i_redirect_pc;
   logic [15:0] i_inm_i;
   logic [25:0] i_inm_j;
   logic [31:0] i_rs;
   logic        o_misaligned;
   logic [31:0] o_debug_pc;

   int total = 0;
   int bad   = 0;

   logic [31:0] imem [2048];

   instruction_fetch_queue dut (
      .i_clock       (i_clock),
      .i_reset_n     (i_reset_n),
      .i_enable      (i_enable),
      .o_imem_addr   (o_imem_addr),
      .o_imem_en     (o_imem_en),
      .i_imem_data   (i_imem_data),
      .o_valid       (o_valid),
      .i_ready       (i_ready),
      .o_ir          (o_ir),
      .o_pc          (o_pc),
      .i_branch      (i_branch),
      .i_jump_rs     (i_jump_rs),
      .i_jump_inm    (i_jump_inm),
      .i_redirect_pc (i_redirect_pc),
      .i_inm_i       (i_inm_i),
      .i_inm_j       (i_inm_j),
      .i_rs          (i_rs),
      .o_misaligned  (o_misaligned),
      .o_debug_pc    (o_debug_pc)
   );

   initial i_clock = 1'b0;
   always #5 i_clock = ~i_clock;

   initial begin
      for (int k = 0; k < 2048; k++) imem[k] = k;
      i_imem_data = '0;
   end

   always @(posedge i_clock) begin
      if (o_imem_en) i_imem_data <= imem[o_imem_addr];
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   function automatic logic [31:0] word_at(input logic [31:0] addr);
      return (addr >> 2) % 2048;
   endfunction

   task automatic idle_inputs();
      i_branch      = 1'b0;
      i_jump_rs     = 1'b0;
      i_jump_inm    = 1'b0;
      i_redirect_pc = '0;
      i_inm_i       = '0;
      i_inm_j       = '0;
      i_rs          = '0;
   endtask

   // Leaves the bench at a falling edge with reset just released.
   task automatic do_reset(input logic ready, input logic enable);
      @(negedge i_clock);
      i_reset_n = 1'b0;
      idle_inputs();
      repeat (2) @(negedge i_clock);
      i_ready   = ready;
      i_enable  = enable;
      i_reset_n = 1'b1;
   endtask

   task automatic test_reset();
      @(negedge i_clock);
      i_reset_n = 1'b0;
      i_enable  = 1'b1;
      i_ready   = 1'b1;
      idle_inputs();
      #1;
      total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b exp=0", o_valid); end
      total++; if (o_imem_en !== 1'b0) begin bad++; $display("FAIL reset_imem_en got=%0b exp=0", o_imem_en); end
      total++; if (o_misaligned !== 1'b0) begin bad++; $display("FAIL reset_misaligned got=%0b exp=0", o_misaligned); end
      total++; if (o_ir !== 32'h0) begin bad++; $display("FAIL reset_ir got=%h exp=0", o_ir); end
      total++; if (o_pc !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h exp=0", o_pc); end
      total++; if (o_debug_pc !== 32'h0) begin bad++; $display("FAIL reset_debug_pc got=%h exp=0", o_debug_pc); end
   endtask

   task automatic test_sequential();
      do_reset(1'b1, 1'b1);
      #1;
      total++; if (o_imem_en !== 1'b1 || o_imem_addr !== 11'd0) begin
         bad++; $display("FAIL seq_first_issue en=%0b addr=%0d exp en=1 addr=0", o_imem_en, o_imem_addr);
      end
      for (int c = 0; c < 12; c++) begin
         total++; if (o_valid !== (c >= 2)) begin
            bad++; $display("FAIL seq_valid cycle=%0d got=%0b exp=%0b", c, o_valid, (c >= 2));
         end
         if (c >= 2) begin
            total++; if (o_ir !== 32'(c - 2) || o_pc !== 32'(4 * (c - 1))) begin
               bad++; $display("FAIL seq_data cycle=%0d ir=%0d pc=%0d exp ir=%0d pc=%0d", c, o_ir, o_pc, c - 2, 4 * (c - 1));
            end
         end
         @(negedge i_clock); #1;
      end
   endtask

   task automatic test_backpressure();
      int issues;
      int got;
      issues = 0;
      got    = 0;
      do_reset(1'b0, 1'b1);
      #1;
      for (int c = 0; c < 10; c++) begin
         if (o_imem_en) issues++;
         @(negedge i_clock); #1;
      end
      total++; if (issues !== 4) begin bad++; $display("FAIL bp_issue_count got=%0d exp=4", issues); end
      total++; if (o_imem_en !== 1'b0) begin bad++; $display("FAIL bp_stalled_en got=%0b exp=0", o_imem_en); end
      total++; if (o_debug_pc !== 32'd16) begin bad++; $display("FAIL bp_debug_pc got=%0d exp=16", o_debug_pc); end
      i_ready = 1'b1;
      #1;
      for (int c = 0; c < 40 && got < 8; c++) begin
         if (o_valid) begin
            total++; if (o_ir !== 32'(got) || o_pc !== 32'(4 * got + 4)) begin
               bad++; $display("FAIL bp_order idx=%0d ir=%0d pc=%0d exp ir=%0d pc=%0d", got, o_ir, o_pc, got, 4 * got + 4);
            end
            got++;
         end
         @(negedge i_clock); #1;
      end
      total++; if (got !== 8) begin bad++; $display("FAIL bp_drain_timeout delivered=%0d exp=8", got); end
   endtask

   task automatic redirect_check(input string name, input logic br, input logic jrs, input logic jinm,
                                 input logic [31:0] rpc, input logic [15:0] ii, input logic [25:0] ij,
                                 input logic [31:0] rs, input logic [31:0] exp_target, input logic exp_mis);
      do_reset(1'b1, 1'b1);
      repeat (5) @(negedge i_clock);
      @(negedge i_clock);
      i_branch = br; i_jump_rs = jrs; i_jump_inm = jinm;
      i_redirect_pc = rpc; i_inm_i = ii; i_inm_j = ij; i_rs = rs;
      #1;
      total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL %s_valid_r got=%0b exp=0", name, o_valid); end
      @(negedge i_clock);
      idle_inputs();
      #1;
      total++; if (o_debug_pc !== exp_target || o_imem_en !== 1'b1 || o_imem_addr !== 11'(word_at(exp_target))) begin
         bad++; $display("FAIL %s_fetch pc=%h en=%0b addr=%0d exp pc=%h en=1 addr=%0d", name, o_debug_pc, o_imem_en, o_imem_addr, exp_target, word_at(exp_target));
      end
      total++; if (o_misaligned !== exp_mis) begin bad++; $display("FAIL %s_misaligned got=%0b exp=%0b", name, o_misaligned, exp_mis); end
      @(negedge i_clock); #1;
      total++; if (o_valid !== 1'b0 || o_misaligned !== 1'b0) begin
         bad++; $display("FAIL %s_r2 valid=%0b mis=%0b exp 0 0", name, o_valid, o_misaligned);
      end
      @(negedge i_clock); #1;
      total++; if (o_valid !== 1'b1 || o_ir !== word_at(exp_target) || o_pc !== exp_target + 32'd4) begin
         bad++; $display("FAIL %s_head valid=%0b ir=%h pc=%h exp valid=1 ir=%h pc=%h", name, o_valid, o_ir, o_pc, word_at(exp_target), exp_target + 32'd4);
      end
      @(negedge i_clock); #1;
      total++; if (o_ir !== word_at(exp_target + 32'd4)) begin
         bad++; $display("FAIL %s_next ir=%h exp=%h", name, o_ir, word_at(exp_target + 32'd4));
      end
   endtask

   task automatic test_branch();
      redirect_check("branch", 1'b1, 1'b0, 1'b0, 32'h20, 16'hFFFC, 26'h0, 32'h0, 32'h10, 1'b0);
   endtask

   task automatic test_jumps();
      redirect_check("jump_inm", 1'b0, 1'b0, 1'b1, 32'h3000_0008, 16'h0, 26'h40, 32'h0, 32'h3000_0100, 1'b0);
      redirect_check("jump_rs", 1'b0, 1'b1, 1'b0, 32'h0, 16'h0, 26'h0, 32'h2A, 32'h28, 1'b1);
   endtask

   task automatic test_simultaneous();
      redirect_check("br_and_jrs", 1'b1, 1'b1, 1'b0, 32'h100, 16'h0002, 26'h0, 32'h201, 32'h108, 1'b0);
   endtask

   task automatic test_reset_midstream();
      do_reset(1'b1, 1'b1);
      repeat (5) @(negedge i_clock);
      @(negedge i_clock);
      i_reset_n = 1'b0;
      #1;
      total++; if (o_valid !== 1'b0 || o_imem_en !== 1'b0 || o_ir !== 32'h0 || o_pc !== 32'h0 || o_debug_pc !== 32'h0) begin
         bad++; $display("FAIL midreset_outputs valid=%0b en=%0b ir=%h pc=%h dpc=%h exp all 0", o_valid, o_imem_en, o_ir, o_pc, o_debug_pc);
      end
      @(negedge i_clock);
      i_reset_n = 1'b1;
      #1;
      total++; if (o_imem_en !== 1'b1 || o_imem_addr !== 11'd0) begin
         bad++; $display("FAIL midreset_restart en=%0b addr=%0d exp en=1 addr=0", o_imem_en, o_imem_addr);
      end
      @(negedge i_clock); #1;
      total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL midreset_stale valid=%0b exp=0", o_valid); end
      @(negedge i_clock); #1;
      total++; if (o_valid !== 1'b1 || o_ir !== 32'h0 || o_pc !== 32'h4) begin
         bad++; $display("FAIL midreset_head valid=%0b ir=%h pc=%h exp valid=1 ir=0 pc=4", o_valid, o_ir, o_pc);
      end
   endtask

   task automatic test_enable();
      do_reset(1'b0, 1'b1);
      @(negedge i_clock);
      @(negedge i_clock);
      i_enable = 1'b0;
      i_ready  = 1'b1;
      #1;
      for (int c = 0; c < 5; c++) begin
         total++; if (o_imem_en !== 1'b0 || o_debug_pc !== 32'd8 || o_valid !== 1'b1 || o_ir !== 32'd0) begin
            bad++; $display("FAIL enable_hold cycle=%0d en=%0b dpc=%0d valid=%0b ir=%0d exp en=0 dpc=8 valid=1 ir=0", c, o_imem_en, o_debug_pc, o_valid, o_ir);
         end
         @(negedge i_clock); #1;
      end
      i_enable = 1'b1;
      #1;
      for (int c = 0; c < 3; c++) begin
         total++; if (o_valid !== 1'b1 || o_ir !== 32'(c) || o_pc !== 32'(4 * c + 4)) begin
            bad++; $display("FAIL enable_resume idx=%0d valid=%0b ir=%0d pc=%0d exp valid=1 ir=%0d pc=%0d", c, o_valid, o_ir, o_pc, c, 4 * c + 4);
         end
         @(negedge i_clock); #1;
      end
   endtask

   task automatic test_random();
      logic [31:0] exp_pc;
      logic [31:0] tgt;
      logic        exp_mis;
      logic        redir;
      logic        popped;
      int          pops;
      int          sel;
      bit          seen;
      exp_pc  = 32'h0;
      exp_mis = 1'b0;
      pops    = 0;
      do_reset(1'b1, 1'b1);
      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(negedge i_clock);
         i_ready  = ($urandom_range(0, 3) != 0);
         i_enable = ($urandom_range(0, 7) != 0);
         sel = $urandom_range(0, 24);
         i_branch   = (sel == 0) || (sel == 3);
         i_jump_rs  = (sel == 1) || (sel == 3);
         i_jump_inm = (sel == 2) || (sel == 3);
         i_redirect_pc = $urandom & 32'hFFFF_FFFC;
         i_inm_i = 16'($urandom);
         i_inm_j = 26'($urandom);
         i_rs    = $urandom;
         #1;
         total++; if (o_misaligned !== exp_mis) begin
            bad++; $display("FAIL rnd_misaligned cycle=%0d got=%0b exp=%0b", cyc, o_misaligned, exp_mis);
         end
         redir  = i_branch | i_jump_rs | i_jump_inm;
         popped = o_valid & i_ready & i_enable;
         if (redir) begin
            total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL rnd_valid_on_redirect cycle=%0d got=%0b exp=0", cyc, o_valid); end
         end
         if (popped) begin
            total++; if (o_ir !== word_at(exp_pc) || o_pc !== exp_pc + 32'd4) begin
               bad++; $display("FAIL rnd_stream cycle=%0d ir=%h pc=%h exp ir=%h pc=%h", cyc, o_ir, o_pc, word_at(exp_pc), exp_pc + 32'd4);
            end
            exp_pc = exp_pc + 32'd4;
            pops++;
         end
         exp_mis = 1'b0;
         if (i_branch) begin
            tgt = i_redirect_pc + 32'($signed(i_inm_i)) * 32'd4;
         end else if (i_jump_rs) begin
            tgt = i_rs & 32'hFFFF_FFFC;
            exp_mis = (i_rs % 4) != 0;
         end else begin
            tgt = (i_redirect_pc & 32'hF000_0000) | (32'(i_inm_j) * 32'd4);
         end
         if (redir) exp_pc = tgt;
      end
      idle_inputs();
      i_ready  = 1'b1;
      i_enable = 1'b1;
      seen = 1'b0;
      for (int c = 0; c < 10 && !seen; c++) begin
         @(negedge i_clock); #1;
         if (o_valid) begin
            seen = 1'b1;
            total++; if (o_ir !== word_at(exp_pc)) begin
               bad++; $display("FAIL rnd_drain ir=%h exp=%h", o_ir, word_at(exp_pc));
            end
         end
      end
      total++; if (!seen) begin bad++; $display("FAIL rnd_liveness_timeout valid=%0b exp=1", o_valid); end
      total++; if (pops < 500) begin bad++; $display("FAIL rnd_throughput pops=%0d exp>=500", pops); end
   endtask

   initial begin
      i_reset_n = 1'b0;
      i_enable  = 1'b0;
      i_ready   = 1'b0;
      idle_inputs();
      test_reset();
      test_sequential();
      test_backpressure();
      test_branch();
      test_jumps();
      test_simultaneous();
      test_reset_midstream();
      test_enable();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
